// File: rtl/bus_select_encoder.sv
// Registered one-hot to binary bus-select encoder with multi-driver conflict detection.
// Optional build macro BUS_SELECT_PRIORITY_EN: lowest set bit wins instead of faulting.
module bus_select_encoder #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 encoderEnable,
  input  logic [IN_WIDTH-1:0]  encoderInput,
  output logic [OUT_WIDTH-1:0] encoderOutput,
  output logic                 outputValid,
  output logic                 conflict,
  output logic [CNT_WIDTH-1:0] conflictCount
);

  typedef enum logic [1:0] {IDLE, DRIVE, FAULT} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} cls_t;

  state_t                 state;
  state_t                 state_next;
  cls_t                   cls;
  logic                   any_set;
  logic                   found;
  logic [OUT_WIDTH-1:0]   code;
  logic [OUT_WIDTH-1:0]   code_next;
  logic                   valid_next;
  logic                   conflict_next;
  logic [CNT_WIDTH-1:0]   count_next;
  logic [CNT_WIDTH-1:0]   count_inc;

  // Lowest set bit gives the code; unique when the request is legal.
  always_comb begin
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (encoderInput[i] && !found) begin
        code  = OUT_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

  assign any_set = |encoderInput;

`ifdef BUS_SELECT_PRIORITY_EN
  always_comb begin
    cls = CLS_NONE;
    if (encoderEnable && any_set) cls = CLS_ONE;
  end
`else
  logic multi_set;
  assign multi_set = |(encoderInput & (encoderInput - IN_WIDTH'(1)));

  always_comb begin
    cls = CLS_NONE;
    if (encoderEnable && any_set) cls = multi_set ? CLS_MULTI : CLS_ONE;
  end
`endif

  assign count_inc = (&conflictCount) ? conflictCount : conflictCount + CNT_WIDTH'(1);

  // State and output registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state         <= IDLE;
      encoderOutput <= '0;
      outputValid   <= 1'b0;
      conflict      <= 1'b0;
      conflictCount <= '0;
    end else begin
      state         <= state_next;
      encoderOutput <= code_next;
      outputValid   <= valid_next;
      conflict      <= conflict_next;
      conflictCount <= count_next;
    end
  end

  // Next-state logic; FAULT is left only through an idle request line.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DRIVE: begin
        case (cls)
          CLS_ONE:   state_next = DRIVE;
          CLS_MULTI: state_next = FAULT;
          default:   state_next = IDLE;
        endcase
      end
      FAULT: begin
        if (cls == CLS_NONE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next output values; the select code is only ever replaced by a new legal grant.
  always_comb begin
    code_next     = encoderOutput;
    valid_next    = outputValid;
    conflict_next = conflict;
    count_next    = conflictCount;
    case (state)
      IDLE, DRIVE: begin
        case (cls)
          CLS_ONE: begin
            code_next  = code;
            valid_next = 1'b1;
          end
          CLS_MULTI: begin
            valid_next    = 1'b0;
            conflict_next = 1'b1;
            count_next    = count_inc;
          end
          default: valid_next = 1'b0;
        endcase
      end
      FAULT: begin
        valid_next = 1'b0;
        if (cls == CLS_NONE) conflict_next = 1'b0;
      end
      default: begin
        valid_next    = 1'b0;
        conflict_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_select_encoder.sv
// Directed bench for bus_select_encoder with a queue scoreboard of expected outputs.
module tb_bus_select_encoder;

  logic        clock = 1'b0;
  logic        clear;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dout;
  logic        valid;
  logic        conf;
  logic [7:0]  cnt;

  logic        en2;
  logic [15:0] din2;
  logic [3:0]  dout2;
  logic        valid2;
  logic        conf2;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] code;
    logic       valid;
    logic       conf;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  bus_select_encoder dut (
    .clock(clock), .clear(clear), .encoderEnable(en), .encoderInput(din),
    .encoderOutput(dout), .outputValid(valid), .conflict(conf), .conflictCount(cnt)
  );

  bus_select_encoder #(.CNT_WIDTH(2)) dut_sat (
    .clock(clock), .clear(clear), .encoderEnable(en2), .encoderInput(din2),
    .encoderOutput(dout2), .outputValid(valid2), .conflict(conf2), .conflictCount(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one request, queue its expected result, compare after the next edge.
  task automatic step(input string tag, input logic e, input logic [15:0] d,
                      input logic [3:0] ecode, input logic ev, input logic ec,
                      input logic [7:0] ecnt);
    exp_t x;
    en  = e;
    din = d;
    x.code = ecode; x.valid = ev; x.conf = ec; x.cnt = ecnt;
    sb.push_back(x);
    @(posedge clock);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk({tag, ".code"},  32'(dout),  32'(x.code));
      chk({tag, ".valid"}, 32'(valid), 32'(x.valid));
      chk({tag, ".conf"},  32'(conf),  32'(x.conf));
      chk({tag, ".cnt"},   32'(cnt),   32'(x.cnt));
    end
  endtask

  task automatic sat_step(input logic [15:0] d, input logic ec, input logic [1:0] ecnt);
    en2  = 1'b1;
    din2 = d;
    @(posedge clock);
    #1;
    chk("sat.conf", 32'(conf2), 32'(ec));
    chk("sat.cnt",  32'(cnt2),  32'(ecnt));
  endtask

  // Grant and fault must never be reported together.
  always @(negedge clock) begin
    if (!clear) chk("invariant", 32'(valid && conf), 32'd0);
  end

  initial begin
    clear = 1'b1;
    en    = 1'b1;
    din   = 16'h8000;
    en2   = 1'b0;
    din2  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.code",  32'(dout),  32'd0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.conf",  32'(conf),  32'd0);
    chk("reset.cnt",   32'(cnt),   32'd0);
    chk("reset.cnt2",  32'(cnt2),  32'd0);
    en    = 1'b0;
    din   = '0;
    clear = 1'b0;

    step("idle", 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 16; i++) begin
      logic [15:0] oh;
      oh = 16'd1 << i;
      step("walk", 1'b1, oh, 4'(i), 1'b1, 1'b0, 8'd0);
    end

    step("rel.drive", 1'b1, 16'h0040, 4'd6, 1'b1, 1'b0, 8'd0);
    step("rel.drop",  1'b0, 16'h0040, 4'd6, 1'b0, 1'b0, 8'd0);
    step("rel.idle",  1'b0, 16'h0000, 4'd6, 1'b0, 1'b0, 8'd0);

`ifndef BUS_SELECT_PRIORITY_EN
    step("cf.enter", 1'b1, 16'h0081, 4'd6, 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++)
      step("cf.hold", 1'b1, 16'h0081, 4'd6, 1'b0, 1'b1, 8'd1);
    step("cf.one",   1'b1, 16'h0004, 4'd6, 1'b0, 1'b1, 8'd1);
    step("cf.none",  1'b1, 16'h0000, 4'd6, 1'b0, 1'b0, 8'd1);
    step("cf.grant", 1'b1, 16'h0004, 4'd2, 1'b1, 1'b0, 8'd1);
    step("cf.drvm",  1'b1, 16'h0300, 4'd2, 1'b0, 1'b1, 8'd2);
    step("cf.off",   1'b0, 16'h0300, 4'd2, 1'b0, 1'b0, 8'd2);
`else
    step("pr.multi", 1'b1, 16'h0081, 4'd0, 1'b1, 1'b0, 8'd0);
    step("pr.a00",   1'b1, 16'h0A00, 4'd9, 1'b1, 1'b0, 8'd0);
    step("pr.none",  1'b0, 16'h0000, 4'd9, 1'b0, 1'b0, 8'd0);
`endif

    // Asynchronous clear while driving a grant.
    step("mid.drive", 1'b1, 16'h0010, 4'd4, 1'b1, 1'b0, 8'(cnt));
    #1 clear = 1'b1;
    #1;
    chk("mid.code",  32'(dout),  32'd0);
    chk("mid.valid", 32'(valid), 32'd0);
    chk("mid.conf",  32'(conf),  32'd0);
    chk("mid.cnt",   32'(cnt),   32'd0);
    en  = 1'b0;
    din = '0;
    #1 clear = 1'b0;
    @(posedge clock);
    #1;
    step("post.clr", 1'b1, 16'h0100, 4'd8, 1'b1, 1'b0, 8'd0);

`ifndef BUS_SELECT_PRIORITY_EN
    sat_step(16'h0003, 1'b1, 2'd1);
    sat_step(16'h0000, 1'b0, 2'd1);
    sat_step(16'h0003, 1'b1, 2'd2);
    sat_step(16'h0000, 1'b0, 2'd2);
    sat_step(16'h0003, 1'b1, 2'd3);
    sat_step(16'h0000, 1'b0, 2'd3);
    sat_step(16'h0003, 1'b1, 2'd3);
    sat_step(16'h0000, 1'b0, 2'd3);
    sat_step(16'h0003, 1'b1, 2'd3);
    sat_step(16'h0000, 1'b0, 2'd3);
`else
    sat_step(16'h0003, 1'b0, 2'd0);
    sat_step(16'h0000, 1'b0, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_select_encoder.md
Name: bus_select_encoder

Overview:
- Registered 16-to-4 one-hot encoder; inverse direction of the register-select decoder.
- Turns per-register "out" strobes from control into a 4-bit bus-multiplexer select code.
- Detects illegal multi-driver requests, flags them and counts them.
- Sits between the control unit and the bus mux.

Parameters:
- IN_WIDTH, 16, number of one-hot request lines; must equal 2**OUT_WIDTH.
- OUT_WIDTH, 4, width of the encoded select code.
- CNT_WIDTH, 8, width of the saturating conflict counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  asynchronous, active-high reset.
- encoderEnable  input  1  request qualifier; encoderInput is ignored when low.
- encoderInput  input  IN_WIDTH  one-hot register-out strobes; bit i requests register i.
- encoderOutput  output  OUT_WIDTH  registered select code.
- outputValid  output  1  high while encoderOutput reflects a legal single request.
- conflict  output  1  high while in FAULT.
- conflictCount  output  CNT_WIDTH  number of FAULT entries, saturating.

Behaviour:
- Reset and clock: one clock, asynchronous active-high reset named clear. While clear is high:
  - state=IDLE, encoderOutput=0, outputValid=0, conflict=0, conflictCount=0.
  - Asserting clear mid-operation takes effect immediately, with no wait for a clock edge.
- Input classification is combinational on the current encoderInput, qualified by encoderEnable:
  - NONE: enable low, or zero bits set.
  - ONE: enable high and exactly one bit set; code = index of that bit.
  - MULTI: enable high and two or more bits set.
- Latency: all outputs are registered, so a request sampled at edge N is visible after edge N. No combinational input-to-output path.
- State machine (IDLE, DRIVE, FAULT):
  - IDLE, on ONE: go to DRIVE; encoderOutput<=code; outputValid<=1.
  - IDLE, on NONE: stay in IDLE; encoderOutput holds its last value; outputValid=0.
  - IDLE, on MULTI: go to FAULT; conflict<=1; conflictCount increments.
  - DRIVE, on ONE: stay in DRIVE; encoderOutput<=new code. Back-to-back different codes update every cycle with no bubble.
  - DRIVE, on NONE: go to IDLE; outputValid<=0; encoderOutput keeps its last code, so the bus select never glitches.
  - DRIVE, on MULTI: go to FAULT; outputValid<=0; conflict<=1; conflictCount increments; encoderOutput holds its last code.
  - FAULT, on MULTI: stay in FAULT. No further increment; one increment per FAULT entry.
  - FAULT, on NONE: go to IDLE; conflict<=0.
  - FAULT, on ONE: stay in FAULT. The line must pass through NONE before a new grant is issued.
- Counter: conflictCount saturates at 2**CNT_WIDTH-1; further FAULT entries leave it unchanged. Only clear resets it.
- Invariant: outputValid and conflict are never high together.
- Decode alignment: bit 0 maps to code 0 and bit 15 to code 15, so that feeding encoderOutput into the register-select decoder reproduces encoderInput.

Optional Feature:
- Macro: BUS_SELECT_PRIORITY_EN
- When defined:
  - MULTI is not a fault. The lowest set bit wins and is treated as ONE with that code.
  - FAULT is unreachable; conflict stays 0 and conflictCount stays 0.
- When undefined: behaviour is exactly as specified in Behaviour above.

Test Plan:
- Reset: hold clear=1 with encoderInput=16'h8000, encoderEnable=1 -> encoderOutput=0, outputValid=0, conflict=0, conflictCount=0. Assert clear mid-DRIVE -> all outputs return to reset values before the next edge.
- Walking one: enable=1, encoderInput=16'h0001 through 16'h8000, one per cycle -> encoderOutput=0..15, each appearing one cycle after its input; outputValid=1 throughout with no gaps.
- Release: in DRIVE with input 16'h0040 (code 6), drop enable -> next cycle outputValid=0, encoderOutput stays 6, state=IDLE.
- Conflict (macro off):
  - Input 16'h0081 -> conflict=1, outputValid=0, conflictCount=1.
  - Hold 16'h0081 for 3 cycles -> count stays 1.
  - Apply 16'h0004 -> still FAULT.
  - Apply 0 -> conflict=0.
  - Apply 16'h0004 -> encoderOutput=2, outputValid=1.
- Saturation (CNT_WIDTH=2): alternate 16'h0003 and 0 five times -> conflictCount reads 1,2,3,3,3.
- Priority (BUS_SELECT_PRIORITY_EN defined): input 16'h0A00 -> encoderOutput=9, outputValid=1, conflict=0, conflictCount=0.
